div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Multi-cycle sequencer for the RV32M divide/remainder group: DIV, DIVU, REM and REMU.
- Sits beside the EX-stage ALU. It accepts an issued divide op, runs a radix-2 restoring shift-subtract iteration, and holds the pipeline with a stall until the result is ready.
- MUL-group ops stay in the combinational ALU and are never handled here.
- Owns its quotient/remainder registers, sign fix-up and the RISC-V corner cases (divide-by-zero, signed overflow).

Parameters:
- DATA_WIDTH, 32, operand/result width; the iteration count equals DATA_WIDTH.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  EX stage presents a valid op this cycle.
- alu_op  input  5  ALU opcode. DIV=5'b01000, DIVU=5'b01001, REM=5'b01010, REMU=5'b01011. Any other value is not a divide op.
- operand_a  input  DATA_WIDTH  dividend (rs1).
- operand_b  input  DATA_WIDTH  divisor (rs2).
- flush  input  1  pipeline flush; aborts the op in flight.
- stall  output  1  freeze IF/ID/EX pipeline registers.
- busy  output  1  registered; high whenever state != IDLE.
- result  output  DATA_WIDTH  quotient or remainder, registered.
- result_valid  output  1  one-cycle pulse; result is valid this cycle.

Behaviour:
- State machine states: IDLE, RUN, DONE.
- Reset (RESET high at an edge): state=IDLE, result=0, result_valid=0, busy=0, internal counters/registers=0.
  - RESET takes priority over every other input, including mid-RUN and mid-DONE.
- Accept condition: a divide op is accepted only when state=IDLE, start=1, alu_op is in the divide set, and flush=0.
  - start is ignored in RUN/DONE.
  - start with a non-divide alu_op is ignored.
- stall is combinational:
  - high when (state=IDLE and start and alu_op is a divide op and flush=0), or state=RUN;
  - low in DONE, so the pipeline advances in the cycle the result is presented.
- Accept cycle (cycle 0), evaluated in priority order:
  - Divisor zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give operand_a. Next state DONE.
  - Signed overflow (DIV/REM, operand_a=0x80000000, operand_b=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0. Next state DONE.
  - Otherwise:
    - For signed ops, latch |a|, |b|, neg_q = a[31]^b[31] and neg_r = a[31]. Unsigned ops latch raw values with neg_q = neg_r = 0.
    - Clear the partial remainder, set count=DATA_WIDTH, latch the op kind.
    - Next state RUN.
- RUN, one quotient bit per cycle:
  - rem' = {rem[W-2:0], dividend[W-1]}; dividend is shifted left.
  - If rem' >= divisor: rem' -= divisor and the quotient LSB = 1; else the quotient LSB = 0.
  - count decrements each cycle.
  - When count reaches 0 after the update (the DATA_WIDTH-th RUN cycle), next state is DONE.
  - RUN occupies cycles 1..32.
- Entry into DONE: result is registered as
  - DIV/DIVU: quotient, negated if neg_q;
  - REM/REMU: remainder, negated if neg_r.
  - Subtraction and negation are modulo 2^DATA_WIDTH.
- DONE: result_valid=1 for exactly one cycle. Next state IDLE, unconditionally.
  - A start seen in DONE is not accepted; the pipeline re-presents it after advancing.
- Latency from the accept edge to result_valid:
  - normal ops: 33 cycles (result_valid high in cycle 33);
  - corner cases: 1 cycle.
- result holds its value after DONE until the next completion or RESET.
- flush:
  - In RUN: next state IDLE; no result_valid; result keeps its old value.
  - In DONE: result_valid still pulses; the consumer discards it.
  - In IDLE with start: nothing is accepted and stall is low.

Test Plan:
- DIVU 100/7 accepted at cycle 0 -> stall high cycles 0..32, result_valid and result=14 at cycle 33, busy low at cycle 34.
- REM a=0xFFFFFF9C (-100), b=7 -> result=0xFFFFFFFE (-2) at cycle 33; DIV same operands -> 0xFFFFFFF2 (-14).
- DIV x/0 -> result=0xFFFFFFFF, result_valid at cycle 1, stall high in cycle 0 only. REMU 0x1234/0 -> result=0x00001234.
- DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000 at cycle 1. REM of the same operands -> result=0.
- Start DIVU 50/5, flush at cycle 10 -> no result_valid, busy low at cycle 11; a new start accepted at cycle 11 completes at cycle 44 with the correct result.
- RESET pulse at cycle 15 of a run, plus start re-asserted during RUN with a different op -> state returns to IDLE, result=0, result_valid never pulses; the extra start during RUN is ignored.

Source files
------------

// File: rtl/div_if.sv
// EX-stage to divide-sequencer bus: op issue, flush and the stall/result return path.
// Master is the pipeline side, slave is the sequencer.
interface div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [4:0]            alu_op;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  flush;
  logic                  stall;
  logic                  busy;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_valid;

  modport master (
    output start, alu_op, operand_a, operand_b, flush,
    input  stall, busy, result, result_valid
  );

  modport slave (
    input  start, alu_op, operand_a, operand_b, flush,
    output stall, busy, result, result_valid
  );
endinterface

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU restoring divider; result_valid 33 cycles after accept (1 for /0 and overflow).
// Backpressure: stall holds the pipeline from the accept cycle through RUN, and drops in DONE.
module div_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic CLK,
  input  logic RESET,
  div_if.slave dbus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] ITERS = CW'(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [W-1:0]  dividend_q;
  logic [W-1:0]  divisor_q;
  logic [W-1:0]  rem_q;
  logic          neg_q;
  logic          neg_r;
  logic          op_is_rem;
  logic [W-1:0]  result_q;
  logic          result_valid_q;
  logic          busy_q;

  // Op decode: 010xx is the divide group, bit0 selects unsigned, bit1 selects remainder.
  logic is_div_op, in_signed, in_rem, accept;
  assign is_div_op = (dbus.alu_op[4:2] == 3'b010);
  assign in_signed = ~dbus.alu_op[0];
  assign in_rem    = dbus.alu_op[1];
  assign accept    = (state == IDLE) && dbus.start && is_div_op && !dbus.flush;

  assign dbus.stall        = accept || (state == RUN);
  assign dbus.busy         = busy_q;
  assign dbus.result       = result_q;
  assign dbus.result_valid = result_valid_q;

  logic          a_neg, b_neg, div_zero, sgn_ovf;
  logic [W-1:0]  a_mag, b_mag;
  assign a_neg    = in_signed & dbus.operand_a[W-1];
  assign b_neg    = in_signed & dbus.operand_b[W-1];
  assign a_mag    = a_neg ? (W'(0) - dbus.operand_a) : dbus.operand_a;
  assign b_mag    = b_neg ? (W'(0) - dbus.operand_b) : dbus.operand_b;
  assign div_zero = (dbus.operand_b == '0);
  assign sgn_ovf  = in_signed && (dbus.operand_a == SMIN) && (dbus.operand_b == '1);

  // Trial remainder keeps the shifted-out bit so divisors >= 2^(W-1) still divide correctly.
  logic [W:0]   trial, trial_sub;
  logic         q_bit;
  logic [W-1:0] rem_nxt, quo_nxt, rem_fin, quo_fin;
  assign trial     = {rem_q, dividend_q[W-1]};
  assign trial_sub = trial - {1'b0, divisor_q};
  assign q_bit     = (trial >= {1'b0, divisor_q});
  assign rem_nxt   = q_bit ? trial_sub[W-1:0] : trial[W-1:0];
  assign quo_nxt   = {dividend_q[W-2:0], q_bit};
  assign rem_fin   = neg_r ? (W'(0) - rem_nxt) : rem_nxt;
  assign quo_fin   = neg_q ? (W'(0) - quo_nxt) : quo_nxt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= IDLE;
      count          <= '0;
      dividend_q     <= '0;
      divisor_q      <= '0;
      rem_q          <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      op_is_rem      <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            if (div_zero) begin
              result_q       <= in_rem ? dbus.operand_a : '1;
              result_valid_q <= 1'b1;
              state          <= DONE;
            end else if (sgn_ovf) begin
              result_q       <= in_rem ? '0 : SMIN;
              result_valid_q <= 1'b1;
              state          <= DONE;
            end else begin
              dividend_q <= a_mag;
              divisor_q  <= b_mag;
              rem_q      <= '0;
              neg_q      <= a_neg ^ b_neg;
              neg_r      <= a_neg;
              op_is_rem  <= in_rem;
              count      <= ITERS;
              state      <= RUN;
            end
          end
        end
        RUN: begin
          if (dbus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            rem_q      <= rem_nxt;
            dividend_q <= quo_nxt;
            count      <= count - 1'b1;
            if (count == CW'(1)) begin
              result_q       <= op_is_rem ? rem_fin : quo_fin;
              result_valid_q <= 1'b1;
              state          <= DONE;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: hand-computed quotients/remainders, corner cases,
// flush and reset abort, with cycle-exact stall/valid checks.
module tb_div_sequencer;
  localparam logic [4:0] OP_DIV  = 5'b01000;
  localparam logic [4:0] OP_DIVU = 5'b01001;
  localparam logic [4:0] OP_REM  = 5'b01010;
  localparam logic [4:0] OP_REMU = 5'b01011;

  logic CLK;
  logic RESET;
  int   total;
  int   bad;

  div_if #(.DATA_WIDTH(32)) dbus ();

  div_sequencer #(.DATA_WIDTH(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .dbus  (dbus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents the op in the current cycle (cycle 0) and follows it to completion at cycle lat.
  // With noise set, a different divide op is held on start during RUN and DONE.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat, input bit noise);
    dbus.start     = 1'b1;
    dbus.alu_op    = op;
    dbus.operand_a = a;
    dbus.operand_b = b;
    #1;
    chk(tag, "stall_c0", dbus.stall, 1);
    for (int c = 1; c <= lat; c++) begin
      step();
      if (noise) begin
        dbus.start     = 1'b1;
        dbus.alu_op    = OP_REM;
        dbus.operand_a = 32'h0000_0055;
        dbus.operand_b = 32'h0000_0003;
      end else begin
        dbus.start = 1'b0;
      end
      #1;
      if (c < lat) begin
        chk(tag, "stall_run", dbus.stall, 1);
        chk(tag, "valid_run", dbus.result_valid, 0);
        chk(tag, "busy_run", dbus.busy, 1);
      end else begin
        chk(tag, "valid_done", dbus.result_valid, 1);
        chk(tag, "result", dbus.result, exp);
        chk(tag, "stall_done", dbus.stall, 0);
        chk(tag, "busy_done", dbus.busy, 1);
      end
    end
    step();
    dbus.start = 1'b0;
    #1;
    chk(tag, "busy_after", dbus.busy, 0);
    chk(tag, "valid_after", dbus.result_valid, 0);
    chk(tag, "result_hold", dbus.result, exp);
  endtask

  initial begin
    int pulses;
    total          = 0;
    bad            = 0;
    RESET          = 1'b1;
    dbus.start     = 1'b0;
    dbus.alu_op    = 5'b0;
    dbus.operand_a = '0;
    dbus.operand_b = '0;
    dbus.flush     = 1'b0;
    step();
    step();
    chk("reset", "busy", dbus.busy, 0);
    chk("reset", "result", dbus.result, 0);
    chk("reset", "valid", dbus.result_valid, 0);
    chk("reset", "stall", dbus.stall, 0);
    RESET = 1'b0;
    step();

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_op("rem_m100_7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 1'b0);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33, 1'b0);
    run_op("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, 1'b0);
    run_op("div_by0", OP_DIV, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("remu_by0", OP_REMU, 32'h0000_1234, 32'd0, 32'h0000_1234, 1, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    run_op("divu_noise", OP_DIVU, 32'd1000, 32'd3, 32'd333, 33, 1'b1);

    // Non-divide op and a flushed divide in IDLE are not accepted.
    dbus.start  = 1'b1;
    dbus.alu_op = 5'b00000;
    #1;
    chk("nondiv", "stall", dbus.stall, 0);
    step();
    dbus.alu_op = OP_DIV;
    dbus.flush  = 1'b1;
    #1;
    chk("nondiv", "busy", dbus.busy, 0);
    chk("flush_idle", "stall", dbus.stall, 0);
    step();
    dbus.start = 1'b0;
    dbus.flush = 1'b0;
    #1;
    chk("flush_idle", "busy", dbus.busy, 0);

    // Flush in RUN at cycle 10 aborts; a new op accepted in cycle 11 completes at 44.
    step();
    dbus.start     = 1'b1;
    dbus.alu_op    = OP_DIVU;
    dbus.operand_a = 32'd50;
    dbus.operand_b = 32'd5;
    #1;
    chk("flush_run", "stall_c0", dbus.stall, 1);
    for (int c = 1; c <= 10; c++) begin
      step();
      dbus.start = 1'b0;
      dbus.flush = (c == 10);
      #1;
    end
    chk("flush_run", "stall_c10", dbus.stall, 1);
    step();
    dbus.flush = 1'b0;
    #1;
    chk("flush_run", "busy_c11", dbus.busy, 0);
    chk("flush_run", "valid_c11", dbus.result_valid, 0);
    chk("flush_run", "result_kept", dbus.result, 333);
    run_op("divu_after_flush", OP_DIVU, 32'd50, 32'd5, 32'd10, 33, 1'b0);

    // RESET at cycle 15 of a run, with an extra start presented during RUN.
    step();
    dbus.start     = 1'b1;
    dbus.alu_op    = OP_DIV;
    dbus.operand_a = 32'd1000;
    dbus.operand_b = 32'd3;
    #1;
    chk("reset_run", "stall_c0", dbus.stall, 1);
    pulses = 0;
    for (int c = 1; c <= 15; c++) begin
      step();
      dbus.start  = (c == 5);
      dbus.alu_op = (c == 5) ? OP_REM : OP_DIV;
      RESET       = (c == 15);
      #1;
      if (dbus.result_valid) pulses++;
    end
    chk("reset_run", "busy_c15", dbus.busy, 1);
    step();
    RESET = 1'b0;
    #1;
    chk("reset_run", "busy", dbus.busy, 0);
    chk("reset_run", "result", dbus.result, 0);
    chk("reset_run", "stall", dbus.stall, 0);
    for (int c = 0; c < 40; c++) begin
      step();
      if (dbus.result_valid) pulses++;
    end
    chk("reset_run", "valid_pulses", 32'(pulses), 0);
    chk("reset_run", "busy_end", dbus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
